// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide controller.
// Divide support is selected by the MULDIV_DIV_EN macro in the RTL that imports this.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int         MULDIV_ITER = 32;
    localparam logic [4:0] ITER_LAST   = 5'(MULDIV_ITER - 1);

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Single combinational step of the shift-add multiplier / restoring divider.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_iter
    import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic        i_div,
`endif
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_opnd,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    // Multiply: hi accumulates the partial product, lo holds the remaining multiplier bits.
    logic [32:0] w_sum;
    assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : 33'd0);

`ifdef MULDIV_DIV_EN
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;

    assign w_shift = {i_hi, i_lo[31]};
    assign w_ge    = (w_shift >= {1'b0, i_opnd});
    assign w_sub   = w_shift[31:0] - i_opnd;

    // NOTE: every output gets a default first so no path through the block leaves a latch.
    always_comb begin
        o_hi = w_sum[32:1];
        o_lo = {w_sum[0], i_lo[31:1]};
        if (i_div) begin
            o_hi = w_ge ? w_sub : w_shift[31:0];
            o_lo = {i_lo[30:0], w_ge};
        end
    end
`else
    assign o_hi = w_sum[32:1];
    assign o_lo = {w_sum[0], i_lo[31:1]};
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO, with hazard stall output.
// Define MULDIV_DIV_EN to build DIV/DIVU; otherwise divide issues are ignored.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_hi,
    input  logic        rd_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_acc_hi, r_acc_lo, r_opnd;
    logic        r_div, r_neg_lo, r_neg_hi, r_div_zero, r_done;

    logic        w_is_div, w_signed, w_start_ok;
    logic [31:0] w_a_mag, w_b_mag;
    logic [31:0] w_next_hi, w_next_lo;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi, w_res_lo;

    assign w_signed = ~op[0];
    assign w_a_mag  = w_signed ? abs32(busA) : busA;
    assign w_b_mag  = w_signed ? abs32(busB) : busB;

`ifdef MULDIV_DIV_EN
    assign w_is_div   = op[1];
    assign w_start_ok = start & (r_state == ST_IDLE);
`else
    assign w_is_div   = 1'b0;
    assign w_start_ok = start & ~op[1] & (r_state == ST_IDLE);
`endif

    muldiv_iter u_iter (
`ifdef MULDIV_DIV_EN
        .i_div  (r_div),
`endif
        .i_hi   (r_acc_hi),
        .i_lo   (r_acc_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_next_hi),
        .o_lo   (w_next_lo)
    );

    // Sign fix-up applied once in DONE; divide-by-zero forces an all-ones quotient.
    assign w_prod = r_neg_lo ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_div) begin
            w_res_hi = r_neg_hi ? -r_acc_hi : r_acc_hi;
            w_res_lo = r_div_zero ? 32'hFFFF_FFFF : (r_neg_lo ? -r_acc_lo : r_acc_lo);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= 5'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_acc_hi   <= 32'd0;
            r_acc_lo   <= 32'd0;
            r_opnd     <= 32'd0;
            r_div      <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state    <= ST_RUN;
                        r_count    <= 5'd0;
                        r_div      <= w_is_div;
                        r_acc_hi   <= 32'd0;
                        r_acc_lo   <= w_is_div ? w_a_mag : w_b_mag;
                        r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
                        r_neg_lo   <= w_signed & (busA[31] ^ busB[31]);
                        r_neg_hi   <= w_is_div & w_signed & busA[31];
                        r_div_zero <= w_is_div & (busB == 32'd0);
                    end else begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                ST_RUN: begin
                    r_acc_hi <= w_next_hi;
                    r_acc_lo <= w_next_lo;
                    r_count  <= r_count + 5'd1;
                    if (r_count == ITER_LAST) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = (r_state != ST_IDLE);
    assign stall = busy & (start | rd_hi | rd_lo | mthi | mtlo);
    assign done  = r_done;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table plus scoreboard, and hand-written corner sequences.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busA, busB, wdata;
    logic        mthi, mtlo, rd_hi, rd_lo;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    muldiv_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .busA  (busA),
        .busB  (busB),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .rd_hi (rd_hi),
        .rd_lo (rd_lo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .stall (stall),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

`ifdef MULDIV_DIV_EN
    localparam int NV = 11;
`else
    localparam int NV = 5;
`endif

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_spurious_done: got done=1 expected no pending operation");
            end else begin
                e = sb_q.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge right after done is expected.
    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        exp_t e;
        start = 1'b1;
        op    = v.op;
        busA  = v.a;
        busB  = v.b;
        e.hi  = v.hi;
        e.lo  = v.lo;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_low"}, 32'(done), 32'd0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(cyc), 32'd33);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   cyc;
        vec_t v;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{OP_MULT,  32'd12345,     32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_6F55};
        vecs[4] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
`ifdef MULDIV_DIV_EN
        vecs[5]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{OP_DIVU, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
        vecs[7]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[8]  = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{OP_DIVU, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[10] = '{OP_DIV,  32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
`endif

        rst = 1'b1; start = 1'b0; op = 2'b00; busA = '0; busB = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_hi = 1'b0; rd_lo = 1'b0;
        #12;
        check("rst_hi",    hi,          32'd0);
        check("rst_lo",    lo,          32'd0);
        check("rst_busy",  32'(busy),   32'd0);
        check("rst_done",  32'(done),   32'd0);
        check("rst_stall", 32'(stall),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven operations, issued back-to-back at the first idle edge.
        for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // MFLO held while a MULTU 3x5 is in flight: stall through DONE, clear with new value.
        start = 1'b1; op = OP_MULTU; busA = 32'd3; busB = 32'd5;
        sb_q.push_back('{32'd0, 32'd15});
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 5) rd_lo = 1'b1;
            #1;
            check($sformatf("rdlo_stall_c%0d", cyc), 32'(stall), (cyc >= 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check("rdlo_busy_cycles", 32'(cyc), 32'd33);
        check("rdlo_stall_release", 32'(stall), 32'd0);
        check("rdlo_lo_value", lo, 32'd15);
        rd_lo = 1'b0;

        // Idle MTLO / MTHI take effect at the next edge without stalling.
        mtlo = 1'b1; wdata = 32'h0000_1234;
        #1;
        check("mtlo_idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_idle_lo", lo, 32'h0000_1234);
        mthi = 1'b1; wdata = 32'h0000_ABCD;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_idle_hi", hi, 32'h0000_ABCD);

        // Reset in the middle of RUN; a busy MTHI must stall and not write.
        start = 1'b1; op = OP_MULTU; busA = 32'd7; busB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) begin
                mthi = 1'b1; wdata = 32'h0000_DEAD;
                #1;
                check("mthi_busy_stall", 32'(stall), 32'd1);
            end
            if (c == 4) begin
                mthi = 1'b0;
                check("mthi_busy_dropped", hi, 32'h0000_ABCD);
            end
            if (c == 10) begin
                rst = 1'b1;
                #1;
                check("midrst_busy", 32'(busy), 32'd0);
                check("midrst_hi",   hi,        32'd0);
                check("midrst_lo",   lo,        32'd0);
                check("midrst_done", 32'(done), 32'd0);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        v = '{OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6};
        run_op(v, "after_rst");

`ifndef MULDIV_DIV_EN
        // Without the divide datapath a DIV issue is ignored entirely.
        start = 1'b1; op = OP_DIV; busA = 32'hFFFF_FFF9; busB = 32'd2;
        #1;
        check("nodiv_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("nodiv_busy_c%0d", c), 32'(busy), 32'd0);
            @(negedge clk);
        end
        check("nodiv_hi", hi, 32'd0);
        check("nodiv_lo", lo, 32'd6);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
